// File: rtl/seven_seg_scan_driver_if.sv
// ============================================================================
//  Module      : seven_seg_scan_driver_if
//  Description : Bundle of the BCD data, display controls and decoder/digit
//                pins shared between a BCD producer and the scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    // Producer side: value to show and display controls
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    load;
    logic                    lamp_test;
    logic                    blank;
    logic                    zero_blank_en;

    // Display side: shared decoder inputs and per-digit common enables
    logic [3:0]              bcd_out;
    logic                    lt_n;
    logic                    bi_n;
    logic                    rbi_n;
    logic [NUM_DIGITS-1:0]   digit_en_n;
    logic                    frame_done;

    modport master (
        output bcd_in, load, lamp_test, blank, zero_blank_en,
        input  bcd_out, lt_n, bi_n, rbi_n, digit_en_n, frame_done
    );

    modport slave (
        input  bcd_in, load, lamp_test, blank, zero_blank_en,
        output bcd_out, lt_n, bi_n, rbi_n, digit_en_n, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
// ============================================================================
//  Module      : seven_seg_scan_driver
//  Description : Time-multiplexed scanner for a multi-digit display behind one
//                shared active-low BCD-to-7-segment decoder. Scans MSD to LSD,
//                inserts anti-ghost guard blanking at each slot start, double-
//                buffers the value per frame and suppresses leading zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD_CYCLES = 2
) (
    input  wire                       clk,
    input  wire                       rst,
    seven_seg_scan_driver_if.slave    bus
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_W   = $clog2(SCAN_DIV);
    localparam int DATA_W  = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_END  = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MSD    = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [CNT_W-1:0]      presc_q,  presc_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic [DATA_W-1:0]     disp_q,   disp_d;
    logic                  lz_q,     lz_d;

    // Registered pin drivers
    logic [3:0]            bcd_out_q,    bcd_out_d;
    logic                  lt_n_q,       lt_n_d;
    logic                  bi_n_q,       bi_n_d;
    logic                  rbi_n_q,      rbi_n_d;
    logic [NUM_DIGITS-1:0] digit_en_n_q, digit_en_n_d;
    logic                  frame_done_q, frame_done_d;

    // Helpers
    logic [3:0]            cur_nib;
    logic                  slot_end;
    logic                  frame_end;
    logic                  in_guard;

    // Next-state and next-pin computation from the current slot state
    always_comb begin
        presc_d      = presc_q + 1'b1;
        idx_d        = idx_q;
        shadow_d     = bus.load ? bus.bcd_in : shadow_q;
        disp_d       = disp_q;
        lz_d         = lz_q;

        cur_nib      = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = disp_q[4*i +: 4];
            end
        end

        slot_end     = (presc_q == PRESC_LAST);
        frame_end    = slot_end && (idx_q == '0);
        in_guard     = (presc_q < GUARD_END);

        if (slot_end) begin
            presc_d = '0;
            // Any nonzero nibble, including 10..15, ends the leading-zero run
            lz_d    = lz_q & (cur_nib == 4'h0);
            if (frame_end) begin
                idx_d  = IDX_MSD;
                // A load landing on the boundary cycle goes straight to display
                disp_d = bus.load ? bus.bcd_in : shadow_q;
                lz_d   = 1'b1;
            end else begin
                idx_d  = idx_q - 1'b1;
            end
        end

        bcd_out_d    = cur_nib;
        lt_n_d       = ~bus.lamp_test;
        // Blank takes priority over lamp test at the decoder
        bi_n_d       = ~(in_guard | bus.blank);
        // The LSD never gets ripple-blanking so a zero value still shows "0"
        rbi_n_d      = bus.lamp_test | ~(bus.zero_blank_en & lz_q & (idx_q != '0));
        frame_done_d = frame_end;

        digit_en_n_d = '1;
        if (!in_guard) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    digit_en_n_d[i] = 1'b0;
                end
            end
        end
    end

    // State and pin registers; reset leaves the display dark at the MSD slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= IDX_MSD;
            shadow_q     <= '0;
            disp_q       <= '0;
            lz_q         <= 1'b1;
            bcd_out_q    <= 4'h0;
            lt_n_q       <= 1'b1;
            bi_n_q       <= 1'b0;
            rbi_n_q      <= 1'b1;
            digit_en_n_q <= '1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            lz_q         <= lz_d;
            bcd_out_q    <= bcd_out_d;
            lt_n_q       <= lt_n_d;
            bi_n_q       <= bi_n_d;
            rbi_n_q      <= rbi_n_d;
            digit_en_n_q <= digit_en_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.bcd_out    = bcd_out_q;
    assign bus.lt_n       = lt_n_q;
    assign bus.bi_n       = bi_n_q;
    assign bus.rbi_n      = rbi_n_q;
    assign bus.digit_en_n = digit_en_n_q;
    assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire
